sram16_ctrl: RTL and testbench
==============================

SRAM16_CTRL -- requirements
Module: sram16_ctrl

Interface
REQ-001 Parameter WAIT, default 2, SRAM strobe-active cycles per access; legal range 1..15.
REQ-002 CLK  input  1  system clock; the block has one clock, reset is synchronous and active-high.
REQ-003 RESET  input  1  synchronous active-high reset, sampled on rising CLK.
REQ-004 Ram  RAM_IF.DEVICE  --  request port fed by the arbiter's Primary side; signals as follows.
REQ-005 Ram.ADDR  input  24  byte address; word address = ADDR[23:1], lane = ADDR[0].
REQ-006 Ram.DIN  input  16  write data.
REQ-007 Ram.DIN_SIZE  input  1  access size: 0 = byte, 1 = 16-bit word.
REQ-008 Ram.OE_n / Ram.WE_n / Ram.RFSH_n  input  1 each  read / write / refresh request, active on the H->L edge.
REQ-009 Ram.DOUT  output  16  read data, valid when ACK_n rises.
REQ-010 Ram.ACK_n  output  1  low while a request is busy; rises on completion.
REQ-011 SRAM_ADDR  output  23  external word address.
REQ-012 SRAM_DQ_O / SRAM_DQ_I  output / input  16 each  data out / data in.
REQ-013 SRAM_DQ_OE  output  1  1 = drive SRAM_DQ_O onto the pads.
REQ-014 SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n  output  1 each  active-low SRAM controls.

Function
REQ-015 Edge detection: registered previous OE_n/WE_n/RFSH_n, each reset to 1; edge = prev high and current low.
REQ-016 Edges are accepted only in IDLE; edges arriving in any other state are dropped.
REQ-017 FSM states: IDLE, SETUP, ACCESS, DONE, RFSH.
REQ-018 Priority when edges coincide: WE > OE > RFSH; the losing edges are discarded.
REQ-019 IDLE + WE or OE edge -> SETUP; IDLE + RFSH edge only -> RFSH.
REQ-020 On leaving IDLE, the block latches ADDR, DIN, DIN_SIZE and the request type.
REQ-021 ACK_n goes low on the cycle after the edge cycle.
REQ-022 SETUP (1 cycle):
- CE_n = 0; SRAM_ADDR, LB_n and UB_n valid.
- For a write, DQ_OE = 1 and DQ_O valid.
- OE_n and WE_n stay high.
REQ-023 ACCESS (WAIT cycles):
- Read: OE_n = 0.
- Write: WE_n = 0.
- An internal counter counts 0..WAIT-1, then the FSM moves to DONE.
REQ-024 DONE (1 cycle):
- OE_n = WE_n = 1, CE_n = 0.
- A read captures SRAM_DQ_I, sampled on the last ACCESS edge, into DOUT.
- ACK_n is registered to 1 at the end of DONE.
- DQ_OE drops at the end of DONE.
- Next state IDLE.
REQ-025 Latency from ACK_n low to ACK_n high is WAIT+2 cycles for reads and writes.
REQ-026 Lanes:
- Word access: LB_n = UB_n = 0.
- Byte access with ADDR[0] = 0: LB_n = 0 only.
- Byte access with ADDR[0] = 1: UB_n = 0 only.
REQ-027 Byte write drives {DIN[7:0], DIN[7:0]} on DQ_O.
REQ-028 Byte read returns {8'h00, selected lane} in DOUT; word read returns SRAM_DQ_I unchanged.
REQ-029 RFSH state (1 cycle): no SRAM activity and all SRAM strobes high; ACK_n low for 1 cycle, then IDLE.
REQ-030 DOUT holds its value until the next completed read.
REQ-031 In IDLE: CE_n = OE_n = WE_n = LB_n = UB_n = 1, DQ_OE = 0.

Reset
REQ-032 On RESET, the block goes to IDLE and sets:
- ACK_n = 1, DOUT = 0, SRAM_ADDR = 0, DQ_O = 0, DQ_OE = 0.
- All SRAM strobes = 1.
- Edge history = 1, wait counter = 0.
REQ-033 RESET asserted mid-access aborts the access: SRAM strobes are high on the first clock edge with RESET = 1, and no DOUT update occurs.

Configuration
REQ-034 Macro SRAM16_RD_CACHE_EN, when defined, adds a one-word read cache with three registers:
- 23-bit tag, 16-bit data, valid bit.
- Valid is cleared on reset.
REQ-035 With SRAM16_RD_CACHE_EN, a read whose word address matches the tag while valid is a hit:
- The FSM goes IDLE -> DONE directly and no SRAM strobe is asserted.
- Hit latency from ACK_n low to ACK_n high is 1 cycle.
- DOUT is taken from the cached word, with the same lane rules.
REQ-036 With SRAM16_RD_CACHE_EN, a read miss updates the tag and data and sets valid at DONE.
REQ-037 With SRAM16_RD_CACHE_EN, any write whose word address matches the tag clears valid; refresh leaves the cache unchanged.
REQ-038 Without SRAM16_RD_CACHE_EN, no cache logic exists and every read performs an SRAM access.

Verification
REQ-039 Word write: WAIT=2, ADDR=24'h000010, DIN=16'hA55A, SIZE=1, WE_n falls -> SRAM_ADDR=23'h000008, WE_n low 2 cycles, LB_n=UB_n=0, DQ_O=A55A, ACK_n low 4 cycles.
REQ-040 Byte read: SRAM returns 16'h1234, ADDR=24'h000011, SIZE=0 -> UB_n=0, LB_n=1, DOUT=16'h0012.
REQ-041 OE_n and WE_n fall in the same cycle -> only the write is performed; the OE request is dropped; exactly one ACK_n pulse.
REQ-042 RFSH_n falls -> ACK_n low exactly 1 cycle; CE_n stays high throughout.
REQ-043 RESET pulsed during ACCESS -> next edge shows strobes high, ACK_n=1, DOUT=0; a new read after reset completes normally.
REQ-044 Cache (with SRAM16_RD_CACHE_EN): read 24'h000020 twice -> second read has no CE_n activity and ACK_n low 1 cycle; then write to 24'h000021 and read 24'h000020 -> SRAM access occurs.

Source files
------------

// File: rtl/sram16_ctrl.sv
// Request-edge driven controller for an asynchronous 16-bit SRAM with byte lanes.
// Define SRAM16_RD_CACHE_EN to add a one-word read cache.
module sram16_ctrl #(
    parameter int unsigned WAIT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [23:0] ADDR,
    input  logic [15:0] DIN,
    input  logic        DIN_SIZE,
    input  logic        OE_n,
    input  logic        WE_n,
    input  logic        RFSH_n,
    output logic [15:0] DOUT,
    output logic        ACK_n,
    output logic [22:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_O,
    input  logic [15:0] SRAM_DQ_I,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_CE_n,
    output logic        SRAM_OE_n,
    output logic        SRAM_WE_n,
    output logic        SRAM_LB_n,
    output logic        SRAM_UB_n
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE, S_RFSH} state_t;

    state_t             state, next_state;
    logic               oe_prev, we_prev, rfsh_prev;
    logic               oe_edge_c, we_edge_c, rfsh_edge_c;
    logic [23:0]        lat_addr;
    logic [15:0]        lat_din;
    logic               lat_size, lat_wr;
    logic [CNT_W-1:0]   cnt;
    logic               hit_c, hit_q;
    logic [15:0]        cache_word_c;

    logic [23:0]        req_addr;
    logic [15:0]        req_din;
    logic               req_size, req_wr, req_hit, req_lb_n, req_ub_n;

    logic               ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d, dq_oe_d, ack_n_d;
    logic [22:0]        addr_d;
    logic [15:0]        dq_o_d, dout_d;

    function automatic logic [15:0] lane_fmt(input logic [15:0] d, input logic size,
                                             input logic lane);
        return size ? d : {8'h00, (lane ? d[15:8] : d[7:0])};
    endfunction

    assign oe_edge_c   = oe_prev   & ~OE_n;
    assign we_edge_c   = we_prev   & ~WE_n;
    assign rfsh_edge_c = rfsh_prev & ~RFSH_n;

`ifdef SRAM16_RD_CACHE_EN
    logic [22:0] tag_q;
    logic [15:0] cdata_q;
    logic        cvalid_q;

    // A read only hits when no write edge pre-empts it.
    assign hit_c        = oe_edge_c & ~we_edge_c & cvalid_q & (ADDR[23:1] == tag_q);
    assign cache_word_c = lane_fmt(cdata_q, DIN_SIZE, ADDR[0]);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tag_q    <= '0;
            cdata_q  <= '0;
            cvalid_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            if (state == S_IDLE)
                hit_q <= hit_c;
            if (state == S_IDLE && we_edge_c && ADDR[23:1] == tag_q)
                cvalid_q <= 1'b0;
            else if (state == S_ACCESS && next_state == S_DONE && !lat_wr) begin
                tag_q    <= lat_addr[23:1];
                cdata_q  <= SRAM_DQ_I;
                cvalid_q <= 1'b1;
            end
        end
    end
`else
    assign hit_c        = 1'b0;
    assign hit_q        = 1'b0;
    assign cache_word_c = '0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic; edges outside IDLE are ignored
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (we_edge_c || oe_edge_c) next_state = hit_c ? S_DONE : S_SETUP;
                else if (rfsh_edge_c)       next_state = S_RFSH;
            end
            S_SETUP:  next_state = S_ACCESS;
            S_ACCESS: if (cnt == CNT_W'(WAIT - 1)) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            S_RFSH:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Edge history, request latches and wait counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            oe_prev   <= 1'b1;
            we_prev   <= 1'b1;
            rfsh_prev <= 1'b1;
            lat_addr  <= '0;
            lat_din   <= '0;
            lat_size  <= 1'b0;
            lat_wr    <= 1'b0;
            cnt       <= '0;
        end else begin
            oe_prev   <= OE_n;
            we_prev   <= WE_n;
            rfsh_prev <= RFSH_n;
            if (state == S_IDLE && next_state != S_IDLE) begin
                lat_addr <= ADDR;
                lat_din  <= DIN;
                lat_size <= DIN_SIZE;
                lat_wr   <= we_edge_c;
            end
            cnt <= (state == S_ACCESS && next_state == S_ACCESS) ? cnt + CNT_W'(1) : '0;
        end
    end

    // In IDLE the request being accepted comes straight from the inputs
    always_comb begin
        req_addr = (state == S_IDLE) ? ADDR      : lat_addr;
        req_din  = (state == S_IDLE) ? DIN       : lat_din;
        req_size = (state == S_IDLE) ? DIN_SIZE  : lat_size;
        req_wr   = (state == S_IDLE) ? we_edge_c : lat_wr;
        req_hit  = (state == S_IDLE) ? hit_c     : hit_q;
        req_lb_n = ~(req_size | ~req_addr[0]);
        req_ub_n = ~(req_size |  req_addr[0]);
    end

    // Output decode from the upcoming state so the pins are registered
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        ack_n_d = 1'b1;
        addr_d  = SRAM_ADDR;
        dq_o_d  = SRAM_DQ_O;
        dout_d  = DOUT;
        unique case (next_state)
            S_SETUP: begin
                ce_n_d  = 1'b0;
                lb_n_d  = req_lb_n;
                ub_n_d  = req_ub_n;
                dq_oe_d = req_wr;
                ack_n_d = 1'b0;
                addr_d  = req_addr[23:1];
                if (req_wr) dq_o_d = req_size ? req_din : {req_din[7:0], req_din[7:0]};
            end
            S_ACCESS: begin
                ce_n_d  = 1'b0;
                lb_n_d  = req_lb_n;
                ub_n_d  = req_ub_n;
                oe_n_d  = req_wr;
                we_n_d  = ~req_wr;
                dq_oe_d = req_wr;
                ack_n_d = 1'b0;
            end
            S_DONE: begin
                ack_n_d = 1'b0;
                if (!req_hit) begin
                    ce_n_d  = 1'b0;
                    lb_n_d  = req_lb_n;
                    ub_n_d  = req_ub_n;
                    dq_oe_d = req_wr;
                end
                if (state == S_ACCESS && !lat_wr)
                    dout_d = lane_fmt(SRAM_DQ_I, lat_size, lat_addr[0]);
                else if (state == S_IDLE && req_hit)
                    dout_d = cache_word_c;
            end
            S_RFSH:  ack_n_d = 1'b0;
            default: ;
        endcase
    end

    // Output register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SRAM_CE_n  <= 1'b1;
            SRAM_OE_n  <= 1'b1;
            SRAM_WE_n  <= 1'b1;
            SRAM_LB_n  <= 1'b1;
            SRAM_UB_n  <= 1'b1;
            SRAM_DQ_OE <= 1'b0;
            ACK_n      <= 1'b1;
            SRAM_ADDR  <= '0;
            SRAM_DQ_O  <= '0;
            DOUT       <= '0;
        end else begin
            SRAM_CE_n  <= ce_n_d;
            SRAM_OE_n  <= oe_n_d;
            SRAM_WE_n  <= we_n_d;
            SRAM_LB_n  <= lb_n_d;
            SRAM_UB_n  <= ub_n_d;
            SRAM_DQ_OE <= dq_oe_d;
            ACK_n      <= ack_n_d;
            SRAM_ADDR  <= addr_d;
            SRAM_DQ_O  <= dq_o_d;
            DOUT       <= dout_d;
        end
    end

endmodule

// File: tb/tb_sram16_ctrl.sv
// Directed bench for sram16_ctrl (WAIT=2); cache steps run only with SRAM16_RD_CACHE_EN.
module tb_sram16_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [23:0] ADDR = '0;
    logic [15:0] DIN = '0;
    logic        DIN_SIZE = 1'b0;
    logic        OE_n = 1'b1;
    logic        WE_n = 1'b1;
    logic        RFSH_n = 1'b1;
    logic [15:0] DOUT;
    logic        ACK_n;
    logic [22:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_O;
    logic [15:0] SRAM_DQ_I = '0;
    logic        SRAM_DQ_OE, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n;

    int checks = 0;
    int failures = 0;
    int a_lo, c_lo, o_lo, w_lo;

    sram16_ctrl #(.WAIT(2)) dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN), .DIN_SIZE(DIN_SIZE),
        .OE_n(OE_n), .WE_n(WE_n), .RFSH_n(RFSH_n), .DOUT(DOUT), .ACK_n(ACK_n),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_I(SRAM_DQ_I),
        .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_CE_n(SRAM_CE_n), .SRAM_OE_n(SRAM_OE_n),
        .SRAM_WE_n(SRAM_WE_n), .SRAM_LB_n(SRAM_LB_n), .SRAM_UB_n(SRAM_UB_n)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts busy cycles from the first ACK_n-low cycle until ACK_n returns high
    task automatic run_txn(output int ack_lo, output int ce_lo, output int oe_lo, output int we_lo);
        int n;
        ack_lo = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; n = 0;
        while (ACK_n === 1'b0 && n < 40) begin
            ack_lo++;
            if (SRAM_CE_n === 1'b0) ce_lo++;
            if (SRAM_OE_n === 1'b0) oe_lo++;
            if (SRAM_WE_n === 1'b0) we_lo++;
            tick();
            n++;
        end
        check("txn_ack_returns_high", ACK_n, 1'b1);
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        int lo;
        lo = 0;
        for (int i = 0; i < n; i++) begin
            if (ACK_n !== 1'b1 || SRAM_CE_n !== 1'b1) lo++;
            tick();
        end
        check(tag, lo, 0);
    endtask

    initial begin
        // Reset
        tick(); tick();
        check("rst_ack", ACK_n, 1'b1);
        check("rst_dout", DOUT, 16'h0000);
        check("rst_addr", SRAM_ADDR, 23'h0);
        check("rst_strobes", {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n}, 5'b11111);
        check("rst_dq", {SRAM_DQ_OE, SRAM_DQ_O}, 17'h0);
        RESET = 1'b0;
        tick();
        check("idle_strobes", {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n}, 5'b11111);

        // Word write to 0x000010
        ADDR = 24'h000010; DIN = 16'hA55A; DIN_SIZE = 1'b1; WE_n = 1'b0;
        tick(); WE_n = 1'b1;
        check("wr_setup_ack", ACK_n, 1'b0);
        check("wr_setup_addr", SRAM_ADDR, 23'h000008);
        check("wr_setup_ctl", {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n}, 5'b01100);
        check("wr_setup_dq", {SRAM_DQ_OE, SRAM_DQ_O}, {1'b1, 16'hA55A});
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("wr_ack_cycles", a_lo, 4);
        check("wr_we_cycles", w_lo, 2);
        check("wr_ce_cycles", c_lo, 4);
        check("wr_oe_cycles", o_lo, 0);
        check("wr_idle_dqoe", SRAM_DQ_OE, 1'b0);
        check("wr_idle_strobes", {SRAM_CE_n, SRAM_LB_n, SRAM_UB_n}, 3'b111);

        // Byte read, upper lane
        SRAM_DQ_I = 16'h1234; ADDR = 24'h000011; DIN_SIZE = 1'b0; OE_n = 1'b0;
        tick(); OE_n = 1'b1;
        check("rdu_setup_ctl", {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n}, 5'b01110);
        check("rdu_setup_dqoe", SRAM_DQ_OE, 1'b0);
        check("rdu_setup_addr", SRAM_ADDR, 23'h000008);
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("rdu_ack_cycles", a_lo, 4);
        check("rdu_oe_cycles", o_lo, 2);
        check("rdu_we_cycles", w_lo, 0);
        check("rdu_dout", DOUT, 16'h0012);

        // Byte read, lower lane
        ADDR = 24'h000030; OE_n = 1'b0;
        tick(); OE_n = 1'b1;
        check("rdl_setup_lanes", {SRAM_LB_n, SRAM_UB_n}, 2'b01);
        check("rdl_setup_addr", SRAM_ADDR, 23'h000018);
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("rdl_dout", DOUT, 16'h0034);

        // Word read
        SRAM_DQ_I = 16'hBEEF; ADDR = 24'h000050; DIN_SIZE = 1'b1; OE_n = 1'b0;
        tick(); OE_n = 1'b1;
        check("rdw_setup_lanes", {SRAM_LB_n, SRAM_UB_n}, 2'b00);
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("rdw_ack_cycles", a_lo, 4);
        check("rdw_dout", DOUT, 16'hBEEF);

        // Byte write, upper lane replicates the low data byte
        ADDR = 24'h000013; DIN = 16'h77CC; DIN_SIZE = 1'b0; WE_n = 1'b0;
        tick(); WE_n = 1'b1;
        check("bwr_setup_dq", SRAM_DQ_O, 16'hCCCC);
        check("bwr_setup_lanes", {SRAM_LB_n, SRAM_UB_n}, 2'b10);
        check("bwr_setup_addr", SRAM_ADDR, 23'h000009);
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("bwr_we_cycles", w_lo, 2);
        check("bwr_dout_hold", DOUT, 16'hBEEF);

        // OE and WE fall together: write wins, single ACK pulse
        ADDR = 24'h000020; DIN = 16'h1111; DIN_SIZE = 1'b1; OE_n = 1'b0; WE_n = 1'b0;
        tick(); OE_n = 1'b1; WE_n = 1'b1;
        check("both_setup_dq", {SRAM_DQ_OE, SRAM_DQ_O}, {1'b1, 16'h1111});
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("both_ack_cycles", a_lo, 4);
        check("both_we_cycles", w_lo, 2);
        check("both_oe_cycles", o_lo, 0);
        quiet_cycles("both_no_second_ack", 6);
        check("both_dout_hold", DOUT, 16'hBEEF);

        // Write edge arriving while busy is dropped
        SRAM_DQ_I = 16'h9999; ADDR = 24'h000060; OE_n = 1'b0;
        tick(); OE_n = 1'b1; WE_n = 1'b0;
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("busy_oe_cycles", o_lo, 2);
        check("busy_we_cycles", w_lo, 0);
        check("busy_dout", DOUT, 16'h9999);
        quiet_cycles("busy_edge_dropped", 4);
        WE_n = 1'b1;
        tick();

        // Refresh
        RFSH_n = 1'b0;
        tick(); RFSH_n = 1'b1;
        check("rfsh_ack", ACK_n, 1'b0);
        check("rfsh_strobes", {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n}, 5'b11111);
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("rfsh_ack_cycles", a_lo, 1);
        check("rfsh_ce_cycles", c_lo, 0);
        check("rfsh_dout_hold", DOUT, 16'h9999);

        // Reset during ACCESS aborts
        SRAM_DQ_I = 16'h5678; ADDR = 24'h000040; OE_n = 1'b0;
        tick(); OE_n = 1'b1;
        tick();
        check("abort_in_access", SRAM_OE_n, 1'b0);
        RESET = 1'b1;
        tick();
        check("abort_strobes", {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n}, 5'b11111);
        check("abort_ack", ACK_n, 1'b1);
        check("abort_dout", DOUT, 16'h0000);
        RESET = 1'b0;
        tick();
        OE_n = 1'b0;
        tick(); OE_n = 1'b1;
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("post_rst_ack_cycles", a_lo, 4);
        check("post_rst_dout", DOUT, 16'h5678);

`ifdef SRAM16_RD_CACHE_EN
        // Miss fills the cache, repeat read hits, matching write invalidates
        SRAM_DQ_I = 16'hCAFE; ADDR = 24'h000020; DIN_SIZE = 1'b1; OE_n = 1'b0;
        tick(); OE_n = 1'b1;
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("c_miss_ack_cycles", a_lo, 4);
        SRAM_DQ_I = 16'h0000; OE_n = 1'b0;
        tick(); OE_n = 1'b1;
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("c_hit_ack_cycles", a_lo, 1);
        check("c_hit_ce_cycles", c_lo, 0);
        check("c_hit_dout", DOUT, 16'hCAFE);
        ADDR = 24'h000021; DIN = 16'h00AB; DIN_SIZE = 1'b0; WE_n = 1'b0;
        tick(); WE_n = 1'b1;
        run_txn(a_lo, c_lo, o_lo, w_lo);
        SRAM_DQ_I = 16'h0BAD; ADDR = 24'h000020; DIN_SIZE = 1'b1; OE_n = 1'b0;
        tick(); OE_n = 1'b1;
        run_txn(a_lo, c_lo, o_lo, w_lo);
        check("c_inval_ce_cycles", c_lo, 4);
        check("c_inval_ack_cycles", a_lo, 4);
        check("c_inval_dout", DOUT, 16'h0BAD);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
